// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and key decoder.
// Scan-code values, held-key bit positions and the (ext, code) -> key_state lookup.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;

  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_S     = 8'h1B;

  localparam int unsigned KEY_STATE_W = 8;
  localparam int unsigned KS_IDX_W    = 3;

  localparam int unsigned KS_LEFT  = 0;
  localparam int unsigned KS_RIGHT = 1;
  localparam int unsigned KS_UP    = 2;
  localparam int unsigned KS_DOWN  = 3;
  localparam int unsigned KS_A     = 4;
  localparam int unsigned KS_D     = 5;
  localparam int unsigned KS_W     = 6;
  localparam int unsigned KS_S     = 7;

  typedef struct packed {
    logic                hit;
    logic [KS_IDX_W-1:0] idx;
  } key_map_t;

  // Map an (extended, scan code) pair onto its held-key bit, if any.
  function automatic key_map_t key_lookup(input logic ext, input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b1;
    m.idx = '0;
    case ({ext, code})
      {1'b1, KEY_LEFT}:  m.idx = KS_IDX_W'(KS_LEFT);
      {1'b1, KEY_RIGHT}: m.idx = KS_IDX_W'(KS_RIGHT);
      {1'b1, KEY_UP}:    m.idx = KS_IDX_W'(KS_UP);
      {1'b1, KEY_DOWN}:  m.idx = KS_IDX_W'(KS_DOWN);
      {1'b0, KEY_A}:     m.idx = KS_IDX_W'(KS_A);
      {1'b0, KEY_D}:     m.idx = KS_IDX_W'(KS_D);
      {1'b0, KEY_W}:     m.idx = KS_IDX_W'(KS_W);
      {1'b0, KEY_S}:     m.idx = KS_IDX_W'(KS_S);
      default:           m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizers, clock glitch filter, 11-bit frame FSM and
// inter-edge timeout. Byte/error indications are combinational in the STOP strobe cycle.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 65_000_000,
  parameter int unsigned TIMEOUT_US  = 2000,
  parameter int unsigned FILTER_LEN  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte_c,
  output logic       byte_valid_c,
  output logic       frame_err_c
);

  localparam int unsigned TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned FLT_W       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             flt_q, flt_d, flt_prev_q;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic             clk_s, dat_s, strobe_c;

  rx_state_e        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             par_q, par_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             timeout_c, stop_ok_c;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // Synchronizers and filter rest at the idle bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      flt_q      <= 1'b1;
      flt_prev_q <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      flt_q      <= flt_d;
      flt_prev_q <= flt_q;
      flt_cnt_q  <= flt_cnt_d;
    end
  end

  // Accept a new clock level only after it has differed for FILTER_LEN cycles.
  always_comb begin
    flt_d     = flt_q;
    flt_cnt_d = '0;
    if (clk_s != flt_q) begin
      if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        flt_d = clk_s;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  assign strobe_c  = flt_prev_q & ~flt_q;
  assign timeout_c = (state_q != ST_IDLE) && !strobe_c && (to_cnt_q == TO_W'(TIMEOUT_CYC));
  assign stop_ok_c = dat_s & (^{shift_q, par_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout_c) begin
      state_d = ST_IDLE;
    end else if (strobe_c) begin
      case (state_q)
        ST_IDLE:   if (!dat_s) state_d = ST_DATA;
        ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data_byte_c  = shift_q;
    byte_valid_c = 1'b0;
    frame_err_c  = timeout_c;
    if (strobe_c && (state_q == ST_STOP)) begin
      byte_valid_c = stop_ok_c;
      frame_err_c  = ~stop_ok_c;
    end
  end

  // Shift register, bit counter, parity capture and timeout counter.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    if ((state_q == ST_IDLE) || timeout_c || strobe_c) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    if (strobe_c && !timeout_c) begin
      case (state_q)
        ST_IDLE:   bit_cnt_d = '0;
        ST_DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        ST_PARITY: par_d = dat_s;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: turns raw bus lines into scan-code events and a
// held-key bitmap for the two players' controls.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 65_000_000,
  parameter int unsigned TIMEOUT_US  = 2000,
  parameter int unsigned FILTER_LEN  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  output logic [7:0]             key_code,
  output logic                   key_ext,
  output logic                   key_break,
  output logic                   key_valid,
  output logic                   frame_err,
  output logic [KEY_STATE_W-1:0] key_state
);

  logic [7:0]             rx_byte_c;
  logic                   rx_valid_c, rx_err_c;
  key_map_t               map_c;

  logic [7:0]             code_q, code_d;
  logic                   ext_q, ext_d, brk_q, brk_d;
  logic                   valid_q, valid_d, err_q, err_d;
  logic                   ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic [KEY_STATE_W-1:0] key_state_q, key_state_d;

  ps2_rx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .TIMEOUT_US (TIMEOUT_US),
    .FILTER_LEN (FILTER_LEN)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .data_byte_c (rx_byte_c),
    .byte_valid_c(rx_valid_c),
    .frame_err_c (rx_err_c)
  );

  assign map_c = key_lookup(ext_pend_q, rx_byte_c);

  // Prefix tracking, event reporting and held-key update.
  always_comb begin
    code_d      = code_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    valid_d     = 1'b0;
    err_d       = rx_err_c;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    key_state_d = key_state_q;
    if (rx_err_c) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (rx_valid_c) begin
      if (rx_byte_c == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else if (rx_byte_c == PS2_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        valid_d    = 1'b1;
        code_d     = rx_byte_c;
        ext_d      = ext_pend_q;
        brk_d      = brk_pend_q;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
        if (map_c.hit) begin
          key_state_d[map_c.idx] = ~brk_pend_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      key_state_q <= '0;
    end else begin
      code_q      <= code_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      key_state_q <= key_state_d;
    end
  end

  assign key_code  = code_q;
  assign key_ext   = ext_q;
  assign key_break = brk_q;
  assign key_valid = valid_q;
  assign frame_err = err_q;
  assign key_state = key_state_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: 1 cycle per microsecond, 80-cycle PS/2 bit period,
// 200-cycle timeout so the whole run stays short.
module tb_ps2_key_decoder;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       frame_err;
  logic [7:0] key_state;

  int checks   = 0;
  int failures = 0;
  int kv_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  int kv0, fe0, t_err;

  ps2_key_decoder #(
    .CLK_FREQ_HZ(1_000_000),
    .TIMEOUT_US (200),
    .FILTER_LEN (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_code (key_code),
    .key_ext  (key_ext),
    .key_break(key_break),
    .key_valid(key_valid),
    .frame_err(frame_err),
    .key_state(key_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (key_valid) kv_cnt++;
    if (frame_err) fe_cnt++;
    if (key_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic pflip,
                                           input logic stop);
    return {stop, (~^b) ^ pflip, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frm, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frm[i];
      wait_cyc(20);
      ps2_clk = 1'b0;
      wait_cyc(40);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pflip, input logic stop);
    send_bits(mk_frame(b, pflip, stop), 11);
    wait_cyc(20);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_code"},  32'(key_code),  32'h0);
    check({tag, "_ext"},   32'(key_ext),   32'h0);
    check({tag, "_brk"},   32'(key_break), 32'h0);
    check({tag, "_valid"}, 32'(key_valid), 32'h0);
    check({tag, "_err"},   32'(frame_err), 32'h0);
    check({tag, "_state"}, 32'(key_state), 32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    wait_cyc(10);

    // Short low glitch with data low: must not start a frame.
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_cyc(3);
    ps2_clk  = 1'b1;
    wait_cyc(5);
    ps2_data = 1'b1;
    wait_cyc(250);
    check("glitch_kv", 32'(kv_cnt), 32'd0);
    check("glitch_fe", 32'(fe_cnt), 32'd0);

    // Make A.
    send_byte(8'h1C, 1'b0, 1'b1);
    check("a_make_kv",    32'(kv_cnt),    32'd1);
    check("a_make_code",  32'(key_code),  32'h1C);
    check("a_make_ext",   32'(key_ext),   32'h0);
    check("a_make_brk",   32'(key_break), 32'h0);
    check("a_make_state", 32'(key_state), 32'h10);

    // Break A.
    send_byte(8'hF0, 1'b0, 1'b1);
    check("f0_no_kv", 32'(kv_cnt), 32'd1);
    send_byte(8'h1C, 1'b0, 1'b1);
    check("a_brk_kv",    32'(kv_cnt),    32'd2);
    check("a_brk_code",  32'(key_code),  32'h1C);
    check("a_brk_brk",   32'(key_break), 32'h1);
    check("a_brk_ext",   32'(key_ext),   32'h0);
    check("a_brk_state", 32'(key_state), 32'h00);

    // Make and break left arrow.
    send_byte(8'hE0, 1'b0, 1'b1);
    send_byte(8'h6B, 1'b0, 1'b1);
    check("left_make_kv",    32'(kv_cnt),    32'd3);
    check("left_make_code",  32'(key_code),  32'h6B);
    check("left_make_ext",   32'(key_ext),   32'h1);
    check("left_make_brk",   32'(key_break), 32'h0);
    check("left_make_state", 32'(key_state), 32'h01);
    send_byte(8'hE0, 1'b0, 1'b1);
    send_byte(8'hF0, 1'b0, 1'b1);
    check("e0f0_no_kv", 32'(kv_cnt), 32'd3);
    send_byte(8'h6B, 1'b0, 1'b1);
    check("left_brk_kv",    32'(kv_cnt),    32'd4);
    check("left_brk_ext",   32'(key_ext),   32'h1);
    check("left_brk_brk",   32'(key_break), 32'h1);
    check("left_brk_state", 32'(key_state), 32'h00);

    // Hold A, then a parity error must leave everything alone.
    send_byte(8'h1C, 1'b0, 1'b1);
    check("a_hold_state", 32'(key_state), 32'h10);
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_byte(8'h1C, 1'b1, 1'b1);
    check("par_fe",    32'(fe_cnt - fe0), 32'd1);
    check("par_kv",    32'(kv_cnt - kv0), 32'd0);
    check("par_state", 32'(key_state),    32'h10);
    check("par_code",  32'(key_code),     32'h1C);

    // A frame error drops a pending E0.
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_byte(8'hE0, 1'b0, 1'b1);
    send_byte(8'h75, 1'b0, 1'b0);
    check("stop_fe", 32'(fe_cnt - fe0), 32'd1);
    check("stop_kv", 32'(kv_cnt - kv0), 32'd0);
    send_byte(8'h75, 1'b0, 1'b1);
    check("post_err_kv",    32'(kv_cnt - kv0), 32'd1);
    check("post_err_code",  32'(key_code),     32'h75);
    check("post_err_ext",   32'(key_ext),      32'h0);
    check("post_err_state", 32'(key_state),    32'h10);

    // Truncated frame: start plus 4 data bits, then idle long past the timeout.
    kv0   = kv_cnt;
    fe0   = fe_cnt;
    t_err = 0;
    send_bits(mk_frame(8'h23, 1'b0, 1'b1), 5);
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (frame_err && (t_err == 0)) t_err = i;
    end
    check("to_fe_once", 32'(fe_cnt - fe0), 32'd1);
    check("to_kv",      32'(kv_cnt - kv0), 32'd0);
    check("to_latency_ok", 32'((t_err >= 146) && (t_err <= 158)), 32'd1);
    send_byte(8'h23, 1'b0, 1'b1);
    check("d_make_code",  32'(key_code),  32'h23);
    check("d_make_state", 32'(key_state), 32'h30);

    // Asynchronous reset in the middle of a frame.
    send_bits(mk_frame(8'h1D, 1'b0, 1'b1), 4);
    wait_cyc(10);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    wait_cyc(3);
    rst_n = 1'b1;
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    wait_cyc(300);
    check("midrst_quiet_fe", 32'(fe_cnt - fe0), 32'd0);
    check("midrst_quiet_kv", 32'(kv_cnt - kv0), 32'd0);
    send_byte(8'h1D, 1'b0, 1'b1);
    check("w_make_kv",    32'(kv_cnt - kv0), 32'd1);
    check("w_make_code",  32'(key_code),     32'h1D);
    check("w_make_ext",   32'(key_ext),      32'h0);
    check("w_make_state", 32'(key_state),    32'h40);

    check("never_both", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
